// File: rtl/dram_pkg.sv
// Shared widths, state and command encodings for the DRAM device-side responder.
package dram_pkg;

  localparam int unsigned DRAM_A_W  = 11;
  localparam int unsigned DRAM_D_W  = 32;
  localparam int unsigned DRAM_BE_W = 4;

  typedef enum logic {
    IDLE,
    ACTIVE
  } dram_state_e;

  typedef enum logic [2:0] {
    NOP,
    ACT,
    CAS_RD,
    CAS_WR,
    PRE
  } dram_cmd_e;

endpackage

// File: rtl/dram_rd_pipe.sv
// Fixed-depth read-return shift register: data and valid travel together, flushed by reset.
module dram_rd_pipe #(
  parameter int unsigned Depth = 5,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o
);

  logic [Depth-1:0] vld_q;
  logic [Width-1:0] data_q [Depth];

  // Data only advances alongside a valid token, so the last stage holds the most recent read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid_i;
      if (in_valid_i) begin
        data_q[0] <= in_data_i;
      end
      for (int i = 1; i < Depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid_o = vld_q[Depth-1];
  assign out_data_o  = data_q[Depth-1];

endmodule

// File: rtl/dram_device_model.sv
// DRAM device-side responder: RAS/CAS command decode, word array with byte-lane writes,
// fixed CAS-latency read return and a sticky protocol timing-violation flag.
module dram_device_model
  import dram_pkg::*;
#(
  parameter int unsigned ROW_W   = 6,
  parameter int unsigned COL_W   = 6,
  parameter int unsigned CAS_LAT = 5,
  parameter int unsigned T_RCD   = 3,
  parameter int unsigned T_RP    = 3
) (
  input  logic                 dram_clk,
  input  logic                 dram_rst,
  input  logic                 DRAM_CSn,
  input  logic                 DRAM_RASn,
  input  logic                 DRAM_CASn,
  input  logic [DRAM_BE_W-1:0] DRAM_WEn,
  input  logic [DRAM_A_W-1:0]  DRAM_A,
  input  logic [DRAM_D_W-1:0]  DRAM_D,
  output logic [DRAM_D_W-1:0]  DRAM_Q,
  output logic                 DRAM_valid,
  output logic                 timing_err
);

  localparam int unsigned AddrW = ROW_W + COL_W;
  localparam int unsigned TMax  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned CntW  = (TMax > 1) ? $clog2(TMax + 1) : 1;

  dram_state_e       state_q, state_d;
  dram_cmd_e         cmd;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              casn_q;
  logic [CntW-1:0]   rcd_q, rcd_d;
  logic [CntW-1:0]   rp_q, rp_d;
  logic              err_q, err_d;
  logic              cas_fall, cas_idle;
  logic              wr_en, rd_en;
  logic              rd_vld_q;
  logic [DRAM_D_W-1:0] rd_data_q;
  logic [AddrW-1:0]  addr;
  logic [DRAM_D_W-1:0] mem [2**AddrW];

  // Upper address bits beyond ROW_W/COL_W alias by design.
  logic unused_a;
  assign unused_a = ^DRAM_A;

  assign addr = {row_q, DRAM_A[COL_W-1:0]};

  // A CASn level held low across cycles counts once, so decode its falling edge.
  assign cas_fall = !DRAM_CASn && casn_q;

  always_comb begin
    cmd      = NOP;
    cas_idle = 1'b0;
    if (!DRAM_CSn) begin
      unique case (state_q)
        IDLE: begin
          if (!DRAM_RASn) begin
            cmd = ACT;
          end
          cas_idle = cas_fall;
        end
        ACTIVE: begin
          if (DRAM_RASn) begin
            cmd = PRE;
          end else if (cas_fall) begin
            cmd = (DRAM_WEn == '1) ? CAS_RD : CAS_WR;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rcd_d   = (rcd_q != '0) ? rcd_q - 1'b1 : '0;
    rp_d    = (rp_q != '0) ? rp_q - 1'b1 : '0;
    err_d   = err_q | cas_idle;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    unique case (cmd)
      ACT: begin
        state_d = ACTIVE;
        row_d   = DRAM_A[ROW_W-1:0];
        rcd_d   = CntW'(T_RCD);
        if (rp_q != '0) begin
          err_d = 1'b1;
        end
      end
      PRE: begin
        state_d = IDLE;
        rp_d    = CntW'(T_RP);
      end
      CAS_RD: begin
        if (rcd_q != '0) begin
          err_d = 1'b1;
        end else begin
          rd_en = 1'b1;
        end
      end
      CAS_WR: begin
        if (rcd_q != '0) begin
          err_d = 1'b1;
        end else begin
          wr_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge dram_clk or negedge dram_rst) begin
    if (!dram_rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      casn_q   <= 1'b1;
      rcd_q    <= '0;
      rp_q     <= '0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      casn_q   <= DRAM_CASn;
      rcd_q    <= rcd_d;
      rp_q     <= rp_d;
      err_q    <= err_d;
      rd_vld_q <= rd_en;
    end
  end

  // Array and its read register are deliberately not reset: contents survive reset.
  always_ff @(posedge dram_clk) begin
    if (wr_en) begin
      for (int k = 0; k < DRAM_BE_W; k++) begin
        if (!DRAM_WEn[k]) begin
          mem[addr][8*k +: 8] <= DRAM_D[8*k +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data_q <= mem[addr];
    end
  end

  dram_rd_pipe #(
    .Depth(CAS_LAT),
    .Width(DRAM_D_W)
  ) u_rd_pipe (
    .clk_i      (dram_clk),
    .rst_ni     (dram_rst),
    .in_valid_i (rd_vld_q),
    .in_data_i  (rd_data_q),
    .out_valid_o(DRAM_valid),
    .out_data_o (DRAM_Q)
  );

  assign timing_err = err_q;

endmodule

// File: tb/tb_dram_device_model.sv
// Bench for dram_device_model: directed scenarios plus randomized traffic against an
// edge-timestamped behavioural model of the device.
module tb_dram_device_model;

  localparam int ROW_W   = 6;
  localparam int COL_W   = 6;
  localparam int CAS_LAT = 5;
  localparam int T_RCD   = 3;
  localparam int T_RP    = 3;
  localparam int NWORDS  = 1 << (ROW_W + COL_W);

  logic        dram_clk  = 1'b0;
  logic        dram_rst  = 1'b0;
  logic        DRAM_CSn  = 1'b1;
  logic        DRAM_RASn = 1'b1;
  logic        DRAM_CASn = 1'b1;
  logic [3:0]  DRAM_WEn  = 4'hF;
  logic [10:0] DRAM_A    = '0;
  logic [31:0] DRAM_D    = '0;
  logic [31:0] DRAM_Q;
  logic        DRAM_valid;
  logic        timing_err;

  dram_device_model #(
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .CAS_LAT(CAS_LAT),
    .T_RCD  (T_RCD),
    .T_RP   (T_RP)
  ) dut (
    .dram_clk  (dram_clk),
    .dram_rst  (dram_rst),
    .DRAM_CSn  (DRAM_CSn),
    .DRAM_RASn (DRAM_RASn),
    .DRAM_CASn (DRAM_CASn),
    .DRAM_WEn  (DRAM_WEn),
    .DRAM_A    (DRAM_A),
    .DRAM_D    (DRAM_D),
    .DRAM_Q    (DRAM_Q),
    .DRAM_valid(DRAM_valid),
    .timing_err(timing_err)
  );

  always #5 dram_clk = ~dram_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc       = 0;
  bit          m_open    = 1'b0;
  int          m_row     = 0;
  int          act_edge  = -1000;
  int          pre_edge  = -1000;
  bit          prev_casn = 1'b1;
  bit          exp_err   = 1'b0;
  bit          exp_valid = 1'b0;
  logic [31:0] exp_q     = '0;
  logic [31:0] exp_qmask = '1;
  bit   [31:0] mmem   [NWORDS];
  bit   [3:0]  mknown [NWORDS];
  bit          sv [64];
  logic [31:0] sd [64];
  logic [31:0] sm [64];
  bit          fall;
  int          addr;
  int          slot;

  function automatic logic [31:0] expand(input bit [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
    return r;
  endfunction

  always @(posedge dram_clk or negedge dram_rst) begin
    if (!dram_rst) begin
      m_open    = 1'b0;
      act_edge  = -1000;
      pre_edge  = -1000;
      prev_casn = 1'b1;
      exp_err   = 1'b0;
      exp_valid = 1'b0;
      exp_q     = '0;
      exp_qmask = '1;
      for (int i = 0; i < 64; i++) sv[i] = 1'b0;
    end else begin
      cyc++;
      fall = !DRAM_CASn && prev_casn;
      if (!DRAM_CSn) begin
        if (!m_open) begin
          if (fall) exp_err = 1'b1;
          if (!DRAM_RASn) begin
            if (cyc - pre_edge <= T_RP) exp_err = 1'b1;
            m_open   = 1'b1;
            m_row    = int'(DRAM_A) % (1 << ROW_W);
            act_edge = cyc;
          end
        end else if (DRAM_RASn) begin
          m_open   = 1'b0;
          pre_edge = cyc;
        end else if (fall) begin
          if (cyc - act_edge <= T_RCD) begin
            exp_err = 1'b1;
          end else begin
            addr = m_row * (1 << COL_W) + int'(DRAM_A) % (1 << COL_W);
            if (DRAM_WEn != 4'hF) begin
              for (int k = 0; k < 4; k++) begin
                if (!DRAM_WEn[k]) begin
                  mmem[addr][8*k +: 8] = DRAM_D[8*k +: 8];
                  mknown[addr][k]      = 1'b1;
                end
              end
            end else begin
              slot     = (cyc + CAS_LAT) % 64;
              sv[slot] = 1'b1;
              sd[slot] = mmem[addr];
              sm[slot] = expand(mknown[addr]);
            end
          end
        end
      end
      prev_casn = DRAM_CASn;
      slot      = cyc % 64;
      exp_valid = sv[slot];
      if (sv[slot]) begin
        exp_q     = sd[slot];
        exp_qmask = sm[slot];
        sv[slot]  = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge dram_clk) begin
    check("model_valid", {31'b0, DRAM_valid}, {31'b0, exp_valid});
    check("model_err", {31'b0, timing_err}, {31'b0, exp_err});
    check("model_q", DRAM_Q & exp_qmask, exp_q & exp_qmask);
  end

  // ---------------- driver ----------------
  bit drv_open = 1'b0;

  task automatic drive(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    @(negedge dram_clk);
    DRAM_CSn  = csn;
    DRAM_RASn = rasn;
    DRAM_CASn = casn;
    DRAM_WEn  = wen;
    DRAM_A    = a;
    DRAM_D    = d;
  endtask

  task automatic nop(input int n);
    repeat (n) drive(1'b0, !drv_open, 1'b1, 4'hF, 11'($urandom), $urandom);
  endtask

  task automatic act(input int row_a);
    drive(1'b0, 1'b0, 1'b1, 4'hF, 11'(row_a), 32'h0);
    drv_open = 1'b1;
  endtask

  task automatic pre();
    drive(1'b0, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0);
    drv_open = 1'b0;
  endtask

  task automatic cas(input int col_a, input logic [3:0] wen, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b0, wen, 11'(col_a), d);
  endtask

  task automatic do_reset();
    @(negedge dram_clk);
    #2;
    dram_rst  = 1'b0;
    DRAM_CSn  = 1'b1;
    DRAM_RASn = 1'b1;
    DRAM_CASn = 1'b1;
    drv_open  = 1'b0;
    @(negedge dram_clk);
    @(negedge dram_clk);
    dram_rst = 1'b1;
  endtask

  // Edges between the read command edge and the first valid pulse (-1 if none within bound).
  task automatic wait_rd(output int lat, output logic [31:0] q);
    lat = -1;
    q   = '0;
    for (int k = 1; k <= 12; k++) begin
      nop(1);
      if (DRAM_valid && lat < 0) begin
        lat = k - 1;
        q   = DRAM_Q;
      end
    end
  endtask

  function automatic logic [10:0] rand_a();
    logic [10:0] a;
    a      = 11'($urandom);
    a[5:0] = 6'($urandom_range(0, 3));
    return a;
  endfunction

  int          tq[$];
  logic [31:0] dq[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          cnt;
    logic [31:0] q;

    // Reset values and quiet idle period.
    @(negedge dram_clk);
    check("rst_valid", {31'b0, DRAM_valid}, 32'd0);
    check("rst_q", DRAM_Q, 32'd0);
    check("rst_err", {31'b0, timing_err}, 32'd0);
    @(negedge dram_clk);
    dram_rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      nop(1);
      if (DRAM_valid) cnt++;
    end
    check("idle_no_valid", cnt, 0);

    // Write then read, exact latency.
    act(5);
    nop(3);
    cas(9, 4'h0, 32'hDEADBEEF);
    nop(1);
    cas(9, 4'hF, 32'h0);
    wait_rd(lat, q);
    check("wr_rd_latency", lat, 5);
    check("wr_rd_data", q, 32'hDEADBEEF);

    // Byte-lane write merge.
    cas(9, 4'b1010, 32'h11223344);
    nop(1);
    cas(9, 4'hF, 32'h0);
    wait_rd(lat, q);
    check("byte_lane_data", q, 32'hDE22BE44);

    // Pipelined reads spaced two cycles apart.
    for (int i = 0; i < 4; i++) begin
      cas(i, 4'h0, 32'hA5A50000 + 32'(i));
      nop(1);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          cas(i, 4'hF, 32'h0);
          nop(1);
        end
      end
      begin
        for (int k = 0; k < 24; k++) begin
          @(negedge dram_clk);
          if (DRAM_valid) begin
            tq.push_back(k);
            dq.push_back(DRAM_Q);
          end
        end
      end
    join
    check("pipe_count", tq.size(), 4);
    for (int i = 0; i < 4 && i < tq.size(); i++) begin
      check("pipe_time", tq[i], 6 + 2 * i);
      check("pipe_data", dq[i], 32'hA5A50000 + 32'(i));
    end

    // tRCD violation: CAS one cycle after ACT is dropped.
    pre();
    nop(3);
    act(7);
    nop(3);
    cas(2, 4'h0, 32'hCAFEF00D);
    nop(1);
    pre();
    nop(3);
    check("err_before_rcd", {31'b0, timing_err}, 32'd0);
    act(7);
    cas(2, 4'h0, 32'h12345678);
    nop(1);
    check("err_rcd", {31'b0, timing_err}, 32'd1);
    nop(3);
    cas(2, 4'hF, 32'h0);
    wait_rd(lat, q);
    check("rcd_no_write", q, 32'hCAFEF00D);

    // tRP violation: ACT one cycle after PRE.
    do_reset();
    check("err_cleared", {31'b0, timing_err}, 32'd0);
    act(1);
    nop(3);
    pre();
    act(1);
    nop(1);
    check("err_rp", {31'b0, timing_err}, 32'd1);

    // Reset while a read is in flight, array survives.
    do_reset();
    act(7);
    nop(3);
    cas(2, 4'hF, 32'h0);
    nop(1);
    do_reset();
    wait_rd(lat, q);
    check("flush_no_valid", lat, -1);
    act(7);
    nop(3);
    cas(2, 4'hF, 32'h0);
    wait_rd(lat, q);
    check("survive_a", q, 32'hCAFEF00D);
    pre();
    nop(3);
    act(5);
    nop(3);
    cas(9, 4'hF, 32'h0);
    wait_rd(lat, q);
    check("survive_b", q, 32'hDE22BE44);

    // Randomized traffic, including aliased addresses, violations, deselects and resets.
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset();
      end else if (r < 6) begin
        drive(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 11'($urandom), $urandom);
      end else if (!drv_open) begin
        if (r < 40) act(int'(rand_a()));
        else nop(1);
      end else if (r < 12) begin
        pre();
      end else if (r < 40) begin
        cas(int'(rand_a()), 4'hF, 32'h0);
        nop(1);
      end else if (r < 65) begin
        cas(int'(rand_a()), 4'($urandom_range(0, 14)), $urandom);
        nop(1);
      end else begin
        nop(1);
      end
    end
    nop(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
